car_mode_sequencer: RTL and testbench

//  Top-level drive sequencer for the line-following car. Consumes the 3-bit line tracker and the

---
 rtl/car_mode_pkg.sv | 44 ++++
 rtl/track_debounce.sv | 38 +++
 rtl/car_mode_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_car_mode_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_mode_pkg.sv
// Shared encodings for the line-following car drive path.
// Mode codes are also decoded by the motor block, so keep these values stable.
// Optional feature macro used by this slice: TRACK_DEBOUNCE_EN (see car_mode_sequencer).
package car_mode_pkg;

  localparam logic [4:0] MODE_CODE_IDLE     = 5'd0;
  localparam logic [4:0] MODE_CODE_START    = 5'd1;
  localparam logic [4:0] MODE_CODE_COUNT    = 5'd2;
  localparam logic [4:0] MODE_CODE_STRAIGHT = 5'd3;
  localparam logic [4:0] MODE_CODE_CHOOSE   = 5'd4;
  localparam logic [4:0] MODE_CODE_LEFT     = 5'd5;
  localparam logic [4:0] MODE_CODE_RIGHT    = 5'd6;
  localparam logic [4:0] MODE_CODE_BACK     = 5'd7;
  localparam logic [4:0] MODE_CODE_STOP     = 5'd8;
  localparam logic [4:0] MODE_CODE_ERROR    = 5'd31;

  typedef enum logic [4:0] {
    MODE_IDLE     = MODE_CODE_IDLE,
    MODE_START    = MODE_CODE_START,
    MODE_COUNT    = MODE_CODE_COUNT,
    MODE_STRAIGHT = MODE_CODE_STRAIGHT,
    MODE_CHOOSE   = MODE_CODE_CHOOSE,
    MODE_LEFT     = MODE_CODE_LEFT,
    MODE_RIGHT    = MODE_CODE_RIGHT,
    MODE_BACK     = MODE_CODE_BACK,
    MODE_STOP     = MODE_CODE_STOP,
    MODE_ERROR    = MODE_CODE_ERROR
  } mode_t;

  localparam logic [1:0] ROUTE_STRAIGHT = 2'b00;
  localparam logic [1:0] ROUTE_LEFT     = 2'b01;
  localparam logic [1:0] ROUTE_RIGHT    = 2'b10;
  localparam logic [1:0] ROUTE_STOP     = 2'b11;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_TURN_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RETRY        = 2'b10;

  // Larger of two integers, used to size the shared timer from the timing parameters.
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/track_debounce.sv
// Per-bit debouncer for the line tracker: a bit only changes at the output once
// the same new value has been seen on DEPTH consecutive samples. DEPTH must be >= 3.
// Only compiled when TRACK_DEBOUNCE_EN is defined.
`ifdef TRACK_DEBOUNCE_EN
module track_debounce #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-2:0][WIDTH-1:0] hist;
  logic [WIDTH-1:0]            stable;

  // A bit is stable when the current sample matches every one of the held samples.
  always_comb begin
    stable = '1;
    for (int k = 0; k < DEPTH-1; k++) begin
      stable = stable & ~(hist[k] ^ din);
    end
  end

  // Shift the sample history and let only stable bits through to the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
      dout <= '0;
    end else begin
      hist <= {hist[DEPTH-3:0], din};
      dout <= (dout & ~stable) | (din & stable);
    end
  end

endmodule
`endif

// File: rtl/car_mode_sequencer.sv
// Drive sequencer for the line-following car: turns tracker and obstacle inputs
// into the 5-bit mode code consumed by the motor block.
// Build option: define TRACK_DEBOUNCE_EN to insert a 4-sample per-bit debouncer
// on the tracker after the sampling register (adds latency to track decisions).
module car_mode_sequencer
  import car_mode_pkg::*;
#(
  parameter int START_DLY  = 100_000_000,
  parameter int TURN_MIN   = 5_000_000,
  parameter int TURN_MAX   = 200_000_000,
  parameter int CHOOSE_CYC = 20_000_000,
  parameter int LOST_CYC   = 10_000_000,
  parameter int BACK_CYC   = 30_000_000,
  parameter int RETRY_MAX  = 3,
  parameter int CLEAR_CYC  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] track,
  input  logic       obstacle,
  input  logic [1:0] route,
  output logic [4:0] mode,
  output logic [7:0] node_cnt,
  output logic       node_tick,
  output logic [1:0] err_code
);

  localparam int MAX_P = max_of(max_of(max_of(START_DLY, TURN_MIN), max_of(TURN_MAX, CHOOSE_CYC)),
                                max_of(max_of(LOST_CYC, BACK_CYC), CLEAR_CYC));
  localparam int TW = $clog2(MAX_P + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);

  // Exit thresholds: a state that compares timer >= N-1 lasts exactly N cycles.
  localparam logic [TW-1:0] LIM_START  = TW'(START_DLY - 1);
  localparam logic [TW-1:0] LIM_TMIN   = TW'(TURN_MIN - 1);
  localparam logic [TW-1:0] LIM_TMAX   = TW'(TURN_MAX - 1);
  localparam logic [TW-1:0] LIM_CHOOSE = TW'(CHOOSE_CYC - 1);
  localparam logic [TW-1:0] LIM_LOST   = TW'(LOST_CYC - 1);
  localparam logic [TW-1:0] LIM_BACK   = TW'(BACK_CYC - 1);
  localparam logic [TW-1:0] LIM_CLEAR  = TW'(CLEAR_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);

  mode_t         state;
  mode_t         state_next;
  logic [2:0]    track_q;
  logic [2:0]    track_seen;
  logic          obstacle_q;
  logic [1:0]    route_q;
  logic [TW-1:0] timer;
  logic [TW-1:0] lost_cnt;
  logic [TW-1:0] clear_cnt;
  logic [RW-1:0] retry_cnt;
  logic          stop_term;
  logic          reenter;
  logic          choose_exit;
  logic          turn_done;
  logic          term_set;
  logic [1:0]    err_set;
  logic          back_entry;

  // Register the asynchronous-world sensor and route inputs once before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      track_q    <= '0;
      obstacle_q <= 1'b0;
      route_q    <= '0;
    end else begin
      track_q    <= track;
      obstacle_q <= obstacle;
      route_q    <= route;
    end
  end

`ifdef TRACK_DEBOUNCE_EN
  track_debounce #(
    .WIDTH (3),
    .DEPTH (4)
  ) u_track_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (track_q),
    .dout (track_seen)
  );
`else
  assign track_seen = track_q;
`endif

  // State register; the mode output is the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MODE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision plus the one-cycle event flags that go with each transition.
  always_comb begin
    state_next  = state;
    reenter     = 1'b0;
    choose_exit = 1'b0;
    turn_done   = 1'b0;
    term_set    = 1'b0;
    err_set     = ERR_NONE;
    case (state)
      MODE_IDLE: begin
        if (start) state_next = MODE_START;
      end
      MODE_START: begin
        state_next = MODE_COUNT;
      end
      MODE_COUNT: begin
        if (timer >= LIM_START) state_next = MODE_STRAIGHT;
      end
      MODE_STRAIGHT: begin
        if (obstacle_q) begin
          state_next = MODE_STOP;
        end else if (track_seen == 3'b111) begin
          state_next = MODE_CHOOSE;
        end else if (track_seen == 3'b000 && lost_cnt >= LIM_LOST) begin
          state_next = MODE_BACK;
        end else if (track_seen == 3'b100 || track_seen == 3'b110) begin
          state_next = MODE_LEFT;
        end else if (track_seen == 3'b001 || track_seen == 3'b011) begin
          state_next = MODE_RIGHT;
        end
      end
      MODE_LEFT, MODE_RIGHT: begin
        if (obstacle_q) begin
          state_next = MODE_STOP;
        end else if (timer >= LIM_TMIN && track_seen == 3'b010) begin
          state_next = MODE_STRAIGHT;
          turn_done  = 1'b1;
        end else if (timer >= LIM_TMAX) begin
          state_next = MODE_ERROR;
          err_set    = ERR_TURN_TIMEOUT;
        end
      end
      MODE_CHOOSE: begin
        if (obstacle_q) begin
          state_next = MODE_STOP;
        end else if (timer >= LIM_CHOOSE) begin
          choose_exit = 1'b1;
          case (route_q)
            ROUTE_STRAIGHT: state_next = MODE_STRAIGHT;
            ROUTE_LEFT:     state_next = MODE_LEFT;
            ROUTE_RIGHT:    state_next = MODE_RIGHT;
            ROUTE_STOP: begin
              state_next = MODE_STOP;
              term_set   = 1'b1;
            end
          endcase
        end
      end
      MODE_BACK: begin
        if (timer >= LIM_BACK) begin
          if (track_seen != 3'b000) begin
            state_next = MODE_STRAIGHT;
          end else if (retry_cnt >= RETRY_LIM) begin
            state_next = MODE_ERROR;
            err_set    = ERR_RETRY;
          end else begin
            reenter = 1'b1;
          end
        end
      end
      MODE_STOP: begin
        if (!stop_term && !obstacle_q && clear_cnt >= LIM_CLEAR) state_next = MODE_STRAIGHT;
      end
      MODE_ERROR: begin
        state_next = MODE_ERROR;
      end
      default: begin
        state_next = MODE_IDLE;
      end
    endcase
  end

  // Mode code straight from the state register.
  always_comb begin
    mode = state;
  end

  assign back_entry = (state_next == MODE_BACK) && ((state != MODE_BACK) || reenter);

  // Shared state timer, lost-line run, obstacle-clear run and retry count.
  // Timers saturate so long waits in IDLE/ERROR/terminal STOP never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= '0;
      lost_cnt  <= '0;
      clear_cnt <= '0;
      retry_cnt <= '0;
    end else begin
      if (state_next != state || reenter) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + TW'(1);
      end

      if (state == MODE_STRAIGHT && state_next == MODE_STRAIGHT && track_seen == 3'b000) begin
        lost_cnt <= lost_cnt + TW'(1);
      end else begin
        lost_cnt <= '0;
      end

      if (state == MODE_STOP && state_next == MODE_STOP && !obstacle_q) begin
        if (clear_cnt != '1) clear_cnt <= clear_cnt + TW'(1);
      end else begin
        clear_cnt <= '0;
      end

      if (turn_done) begin
        retry_cnt <= '0;
      end else if (back_entry && retry_cnt != RETRY_LIM) begin
        retry_cnt <= retry_cnt + RW'(1);
      end
    end
  end

  // Intersection counter, node pulse, latched error cause and terminal-stop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      node_cnt  <= '0;
      node_tick <= 1'b0;
      err_code  <= ERR_NONE;
      stop_term <= 1'b0;
    end else begin
      node_tick <= choose_exit;
      if (choose_exit) node_cnt <= node_cnt + 8'd1;
      if (err_set != ERR_NONE) err_code <= err_set;
      if (term_set) stop_term <= 1'b1;
    end
  end

endmodule

// File: tb/tb_car_mode_sequencer.sv
// Self-checking bench for car_mode_sequencer with short timing parameters.
// Directed scenarios followed by randomized input segments, all checked every
// cycle against a behavioural model of the sequencing rules.
module tb_car_mode_sequencer;

  localparam int P_START  = 6;
  localparam int P_TMIN   = 4;
  localparam int P_TMAX   = 10;
  localparam int P_CHOOSE = 5;
  localparam int P_LOST   = 4;
  localparam int P_BACK   = 5;
  localparam int P_RETRY  = 3;
  localparam int P_CLEAR  = 6;

  localparam int M_IDLE = 0, M_START = 1, M_COUNT = 2, M_STRAIGHT = 3, M_CHOOSE = 4;
  localparam int M_LEFT = 5, M_RIGHT = 6, M_BACK = 7, M_STOP = 8, M_ERROR = 31;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] track = 3'b010;
  logic       obstacle = 1'b0;
  logic [1:0] route = 2'b00;
  logic [4:0] mode;
  logic [7:0] node_cnt;
  logic       node_tick;
  logic [1:0] err_code;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state: what mode the car is in, how long it has been there,
  // and the inputs as the sequencer saw them one cycle ago.
  int m_mode = M_IDLE;
  int m_cycles_in_mode = 0;
  int m_zero_run = 0;
  int m_clear_run = 0;
  int m_attempts = 0;
  bit m_terminal = 0;
  int m_nodes = 0;
  bit m_tick = 0;
  int m_err = 0;
  int seen_track = 0;
  bit seen_obs = 0;
  int seen_route = 0;

  car_mode_sequencer #(
    .START_DLY  (P_START),
    .TURN_MIN   (P_TMIN),
    .TURN_MAX   (P_TMAX),
    .CHOOSE_CYC (P_CHOOSE),
    .LOST_CYC   (P_LOST),
    .BACK_CYC   (P_BACK),
    .RETRY_MAX  (P_RETRY),
    .CLEAR_CYC  (P_CLEAR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .track     (track),
    .obstacle  (obstacle),
    .route     (route),
    .mode      (mode),
    .node_cnt  (node_cnt),
    .node_tick (node_tick),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // One comparison: count it and report any difference.
  task automatic checkOutput(input string tag, input int unsigned got, input int unsigned want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Advance the model by one clock edge using the rules of the drive sequencer.
  task automatic modelStep(input bit r, input bit st, input int tk, input bit ob, input int rt);
    int  nxt;
    bit  again;
    int  elapsed;
    if (r) begin
      m_mode = M_IDLE; m_cycles_in_mode = 0; m_zero_run = 0; m_clear_run = 0;
      m_attempts = 0; m_terminal = 0; m_nodes = 0; m_tick = 0; m_err = 0;
      seen_track = 0; seen_obs = 0; seen_route = 0;
      return;
    end
    nxt = m_mode;
    again = 0;
    m_tick = 0;
    elapsed = m_cycles_in_mode + 1;
    case (m_mode)
      M_IDLE:   if (st) nxt = M_START;
      M_START:  nxt = M_COUNT;
      M_COUNT:  if (elapsed >= P_START) nxt = M_STRAIGHT;
      M_STRAIGHT: begin
        m_zero_run = (seen_track == 0) ? m_zero_run + 1 : 0;
        if (seen_obs) nxt = M_STOP;
        else if (seen_track == 7) nxt = M_CHOOSE;
        else if (m_zero_run >= P_LOST) nxt = M_BACK;
        else if (seen_track == 4 || seen_track == 6) nxt = M_LEFT;
        else if (seen_track == 1 || seen_track == 3) nxt = M_RIGHT;
      end
      M_LEFT, M_RIGHT: begin
        if (seen_obs) nxt = M_STOP;
        else if (elapsed >= P_TMIN && seen_track == 2) begin
          nxt = M_STRAIGHT;
          m_attempts = 0;
        end else if (elapsed >= P_TMAX) begin
          nxt = M_ERROR;
          m_err = 1;
        end
      end
      M_CHOOSE: begin
        if (seen_obs) nxt = M_STOP;
        else if (elapsed >= P_CHOOSE) begin
          m_tick = 1;
          m_nodes = (m_nodes + 1) % 256;
          case (seen_route)
            0: nxt = M_STRAIGHT;
            1: nxt = M_LEFT;
            2: nxt = M_RIGHT;
            default: begin nxt = M_STOP; m_terminal = 1; end
          endcase
        end
      end
      M_BACK: begin
        if (elapsed >= P_BACK) begin
          if (seen_track != 0) nxt = M_STRAIGHT;
          else if (m_attempts >= P_RETRY) begin nxt = M_ERROR; m_err = 2; end
          else again = 1;
        end
      end
      M_STOP: begin
        m_clear_run = seen_obs ? 0 : m_clear_run + 1;
        if (!m_terminal && m_clear_run >= P_CLEAR) nxt = M_STRAIGHT;
      end
      default: nxt = m_mode;
    endcase
    if (nxt != m_mode || again) begin
      m_cycles_in_mode = 0;
      if (nxt == M_BACK && m_attempts < P_RETRY) m_attempts++;
    end else begin
      m_cycles_in_mode++;
    end
    if (nxt != M_STRAIGHT) m_zero_run = 0;
    if (nxt != M_STOP) m_clear_run = 0;
    m_mode = nxt;
    seen_track = tk;
    seen_obs = ob;
    seen_route = rt;
  endtask

  // Hold one input pattern for n cycles, checking every output after each edge.
  task automatic applyStimulus(input bit r, input bit st, input logic [2:0] tk,
                               input bit ob, input logic [1:0] rt, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r; start = st; track = tk; obstacle = ob; route = rt;
      @(posedge clk);
      modelStep(r, st, int'(tk), ob, int'(rt));
      @(negedge clk);
      checkOutput("mode", mode, m_mode);
      checkOutput("node_cnt", node_cnt, m_nodes);
      checkOutput("node_tick", node_tick, m_tick);
      checkOutput("err_code", err_code, m_err);
    end
  endtask

  // Reset, start pulse and countdown into STRAIGHT with the car centred on the line.
  task automatic launch();
    applyStimulus(1, 0, 3'b010, 0, 2'b00, 1);
    applyStimulus(0, 1, 3'b010, 0, 2'b00, 1);
    applyStimulus(0, 0, 3'b010, 0, 2'b00, P_START + 3);
  endtask

  int seg_len;
  logic [2:0] rtrack;
  logic [2:0] track_pool [8];

  initial begin
    track_pool[0] = 3'b010; track_pool[1] = 3'b010; track_pool[2] = 3'b000;
    track_pool[3] = 3'b110; track_pool[4] = 3'b011; track_pool[5] = 3'b111;
    track_pool[6] = 3'b100; track_pool[7] = 3'b101;

    // Reset state and start countdown.
    applyStimulus(1, 0, 3'b010, 0, 2'b00, 2);
    checkOutput("rst_mode", mode, M_IDLE);
    checkOutput("rst_node_cnt", node_cnt, 0);
    checkOutput("rst_err", err_code, 0);
    applyStimulus(0, 1, 3'b010, 0, 2'b00, 1);
    checkOutput("start_mode", mode, M_START);
    applyStimulus(0, 0, 3'b010, 0, 2'b00, P_START + 3);
    checkOutput("count_done", mode, M_STRAIGHT);

    // Lane correction left, early centre ignored until TURN_MIN.
    applyStimulus(0, 0, 3'b110, 0, 2'b00, 2);
    checkOutput("left_entry", mode, M_LEFT);
    applyStimulus(0, 0, 3'b010, 0, 2'b00, 8);
    checkOutput("left_exit", mode, M_STRAIGHT);

    // Intersection routed left.
    applyStimulus(0, 0, 3'b111, 0, 2'b01, 2);
    checkOutput("choose_entry", mode, M_CHOOSE);
    applyStimulus(0, 0, 3'b010, 0, 2'b01, 14);
    checkOutput("route_node_cnt", node_cnt, 1);
    checkOutput("route_done", mode, M_STRAIGHT);

    // Lost line: retries exhausted, error sticky, start ignored, reset recovers.
    applyStimulus(0, 0, 3'b000, 0, 2'b00, 40);
    checkOutput("lost_error", mode, M_ERROR);
    checkOutput("lost_err_code", err_code, 2);
    applyStimulus(0, 1, 3'b000, 0, 2'b00, 1);
    applyStimulus(0, 0, 3'b000, 0, 2'b00, 3);
    checkOutput("error_sticky", mode, M_ERROR);
    applyStimulus(1, 0, 3'b000, 0, 2'b00, 1);
    checkOutput("error_rst", mode, M_IDLE);

    // Obstacle during RIGHT, interrupted clearance, then full clearance.
    launch();
    applyStimulus(0, 0, 3'b011, 0, 2'b00, 2);
    applyStimulus(0, 0, 3'b011, 1, 2'b00, 3);
    checkOutput("obstacle_stop", mode, M_STOP);
    applyStimulus(0, 0, 3'b010, 0, 2'b00, P_CLEAR - 1);
    applyStimulus(0, 0, 3'b010, 1, 2'b00, 2);
    checkOutput("clear_short", mode, M_STOP);
    applyStimulus(0, 0, 3'b010, 0, 2'b00, P_CLEAR + 2);
    checkOutput("clear_full", mode, M_STRAIGHT);

    // Reset in the middle of BACK.
    applyStimulus(0, 0, 3'b000, 0, 2'b00, 7);
    checkOutput("back_entry", mode, M_BACK);
    applyStimulus(1, 0, 3'b000, 0, 2'b00, 1);
    checkOutput("back_rst_mode", mode, M_IDLE);
    checkOutput("back_rst_cnt", node_cnt, 0);
    checkOutput("back_rst_err", err_code, 0);

    // Route stop is terminal even when the path is clear.
    launch();
    applyStimulus(0, 0, 3'b111, 0, 2'b11, 2);
    applyStimulus(0, 0, 3'b010, 0, 2'b11, P_CHOOSE + 20);
    checkOutput("terminal_stop", mode, M_STOP);
    checkOutput("terminal_cnt", node_cnt, 1);

    // Randomized segments.
    launch();
    for (int s = 0; s < 600; s++) begin
      seg_len = $urandom_range(1, 8);
      rtrack = track_pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 39) == 0) begin
        applyStimulus(1, 0, rtrack, 0, 2'($urandom_range(0, 3)), 1);
      end else if ($urandom_range(0, 7) == 0) begin
        applyStimulus(0, 1, rtrack, 0, 2'($urandom_range(0, 3)), 1);
      end
      applyStimulus(0, 0, rtrack, ($urandom_range(0, 9) == 0),
                    2'($urandom_range(0, 3)), seg_len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
